// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sa_pkg
//  Brief    : Shared FSM state encoding, op_mode codes and latency helper for
//             the systolic-array matrix-multiply engine.
//  Revision : 1.0 - initial release
// ============================================================================
package sa_pkg;

    // Engine state encoding
    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_READY   = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    typedef logic [1:0] sa_state_t;

    // op_mode codes; 2'b11 is reserved and behaves like overwrite
    localparam logic [1:0] OP_OVERWRITE  = 2'b00;
    localparam logic [1:0] OP_ACCUMULATE = 2'b01;
    localparam logic [1:0] OP_SUBTRACT   = 2'b10;

    // Cycles for the last skewed operand pair to reach the far corner PE
    function automatic int sa_latency(input int x, input int n, input int y);
        return n + x + y - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
//  Module   : sa_pe
//  Brief    : Systolic processing element: registered A/B forwarding plus a
//             signed MAC. Define SA_SAT_EN for saturating accumulation,
//             otherwise the accumulator wraps modulo 2^OUT_LEN.
//  Revision : 1.0 - initial release
// ============================================================================
module sa_pe
    import sa_pkg::*;
#(
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 20
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic                      start,
    input  logic                      clr_acc,
    input  logic                      en,
    input  logic                      sub,
    input  logic signed [IN_LEN-1:0]  a_in,
    input  logic signed [IN_LEN-1:0]  b_in,
    output logic signed [IN_LEN-1:0]  a_out,
    output logic signed [IN_LEN-1:0]  b_out,
    output logic signed [OUT_LEN-1:0] acc
);

    localparam int c_PW = 2 * IN_LEN;
    localparam int c_W  = ((OUT_LEN > c_PW) ? OUT_LEN : c_PW) + 2;

    logic signed [IN_LEN-1:0]  r_a;
    logic signed [IN_LEN-1:0]  r_b;
    logic signed [OUT_LEN-1:0] r_acc;

    logic signed [c_PW-1:0]    w_prod;
    logic signed [c_W-1:0]     w_prod_x;
    logic signed [c_W-1:0]     w_acc_x;
    logic signed [c_W-1:0]     w_sum;
    logic signed [OUT_LEN-1:0] w_next;

    // Guard bits make the wide sum exact, so overflow is judged once per update
    assign w_prod   = a_in * b_in;
    assign w_prod_x = {{(c_W - c_PW){w_prod[c_PW-1]}}, w_prod};
    assign w_acc_x  = {{(c_W - OUT_LEN){r_acc[OUT_LEN-1]}}, r_acc};
    assign w_sum    = sub ? (w_acc_x - w_prod_x) : (w_acc_x + w_prod_x);

`ifdef SA_SAT_EN
    logic [c_W-OUT_LEN:0] w_hi;
    logic                 w_fits;
    assign w_hi   = w_sum[c_W-1:OUT_LEN-1];
    assign w_fits = (&w_hi) || (~|w_hi);
    assign w_next = w_fits ? w_sum[OUT_LEN-1:0]
                  : (w_sum[c_W-1] ? {1'b1, {(OUT_LEN-1){1'b0}}}
                                  : {1'b0, {(OUT_LEN-1){1'b1}}});
`else
    logic w_unused_hi;
    assign w_next      = w_sum[OUT_LEN-1:0];
    assign w_unused_hi = ^w_sum[c_W-1:OUT_LEN];
`endif

    // Forwarding registers are flushed on start so stale operands never mix in
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (start) begin
            r_a <= '0;
            r_b <= '0;
            if (clr_acc) r_acc <= '0;
        end else if (en) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_acc <= w_next;
        end
    end

    assign a_out = r_a;
    assign b_out = r_b;
    assign acc   = r_acc;

endmodule
`default_nettype wire

// File: rtl/sa_matmul_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sa_matmul_engine
//  Brief    : X-by-Y output-stationary systolic array computing C = A*B from
//             streamed A (row-major) and B (column-major); streams C out.
//             Macro SA_SAT_EN selects saturating accumulation.
//  Revision : 1.0 - initial release
// ============================================================================
module sa_matmul_engine
    import sa_pkg::*;
#(
    parameter int X       = 3,
    parameter int N       = 3,
    parameter int Y       = 3,
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 20
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic [1:0]         op_mode,
    input  logic               SA_start,
    input  logic               Xin_val,
    output logic               Xin_rdy,
    input  logic [IN_LEN-1:0]  Xin_data,
    input  logic               Yin_val,
    output logic               Yin_rdy,
    input  logic [IN_LEN-1:0]  Yin_data,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [OUT_LEN-1:0] out_data,
    output logic               busy,
    output logic               done
);

    localparam int c_ALEN = X * N;
    localparam int c_BLEN = N * Y;
    localparam int c_CLEN = X * Y;
    localparam int c_LAT  = sa_latency(X, N, Y);
    localparam int c_AW   = $clog2(c_ALEN + 1);
    localparam int c_BW   = $clog2(c_BLEN + 1);
    localparam int c_CW   = $clog2(c_CLEN + 1);
    localparam int c_TW   = $clog2(c_LAT + 1);

    sa_state_t         r_state;
    logic [c_AW-1:0]   r_xcnt;
    logic [c_BW-1:0]   r_ycnt;
    logic [c_TW-1:0]   r_tcnt;
    logic [c_CW-1:0]   r_ocnt;
    logic              r_sub;
    logic [IN_LEN-1:0] r_abuf [c_ALEN];
    logic [IN_LEN-1:0] r_bbuf [c_BLEN];

    logic w_x_take, w_y_take, w_start, w_clr, w_mode_sub, w_x_full, w_y_full, w_last;

    assign w_x_full   = (r_xcnt == c_AW'(c_ALEN));
    assign w_y_full   = (r_ycnt == c_BW'(c_BLEN));
    assign Xin_rdy    = (r_state == S_LOAD) && !w_x_full;
    assign Yin_rdy    = (r_state == S_LOAD) && !w_y_full;
    assign w_x_take   = Xin_val && Xin_rdy;
    assign w_y_take   = Yin_val && Yin_rdy;
    assign w_start    = (r_state == S_READY) && SA_start;
    assign w_mode_sub = (op_mode == OP_SUBTRACT);
    assign w_clr      = !((op_mode == OP_ACCUMULATE) || (op_mode == OP_SUBTRACT));
    assign w_last     = (r_ocnt == c_CW'(c_CLEN - 1));

    assign out_val = (r_state == S_DRAIN);
    assign busy    = (r_state == S_COMPUTE) || (r_state == S_DRAIN);
    assign done    = out_val && out_rdy && w_last;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= S_LOAD;
            r_xcnt  <= '0;
            r_ycnt  <= '0;
            r_tcnt  <= '0;
            r_ocnt  <= '0;
            r_sub   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_x_take) r_xcnt <= r_xcnt + 1'b1;
                    if (w_y_take) r_ycnt <= r_ycnt + 1'b1;
                    if (w_x_full && w_y_full) r_state <= S_READY;
                end
                S_READY: begin
                    if (SA_start) begin
                        r_sub   <= w_mode_sub;
                        r_tcnt  <= '0;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (r_tcnt == c_TW'(c_LAT - 1)) begin
                        r_ocnt  <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    if (out_rdy) begin
                        if (w_last) begin
                            r_xcnt  <= '0;
                            r_ycnt  <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            r_ocnt <= r_ocnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < c_ALEN; e++)
            if (w_x_take && (r_xcnt == c_AW'(e))) r_abuf[e] <= Xin_data;
        for (int e = 0; e < c_BLEN; e++)
            if (w_y_take && (r_ycnt == c_BW'(e))) r_bbuf[e] <= Yin_data;
    end

    // Row i / column j are delayed by i / j cycles so A[i][k] meets B[k][j] at PE(i,j)
    logic signed [IN_LEN-1:0] w_a_inj [X];
    logic signed [IN_LEN-1:0] w_b_inj [Y];

    always_comb begin
        for (int i = 0; i < X; i++) begin
            w_a_inj[i] = '0;
            for (int k = 0; k < N; k++)
                if ((r_state == S_COMPUTE) && (int'(r_tcnt) == i + k))
                    w_a_inj[i] = r_abuf[i*N + k];
        end
        for (int j = 0; j < Y; j++) begin
            w_b_inj[j] = '0;
            for (int k = 0; k < N; k++)
                if ((r_state == S_COMPUTE) && (int'(r_tcnt) == j + k))
                    w_b_inj[j] = r_bbuf[j*N + k];
        end
    end

    logic signed [IN_LEN-1:0]  w_a   [X][Y+1];
    logic signed [IN_LEN-1:0]  w_b   [X+1][Y];
    logic signed [OUT_LEN-1:0] w_acc [c_CLEN];
    logic [X-1:0]              w_unused_a;
    logic [Y-1:0]              w_unused_b;

    for (genvar i = 0; i < X; i++) begin : g_row
        assign w_a[i][0]     = w_a_inj[i];
        assign w_unused_a[i] = ^w_a[i][Y];
        for (genvar j = 0; j < Y; j++) begin : g_col
            sa_pe #(
                .IN_LEN  (IN_LEN),
                .OUT_LEN (OUT_LEN)
            ) u_pe (
                .clk     (clk),
                .sys_rst (sys_rst),
                .start   (w_start),
                .clr_acc (w_clr),
                .en      (r_state == S_COMPUTE),
                .sub     (r_sub),
                .a_in    (w_a[i][j]),
                .b_in    (w_b[i][j]),
                .a_out   (w_a[i][j+1]),
                .b_out   (w_b[i+1][j]),
                .acc     (w_acc[i*Y + j])
            );
        end
    end

    for (genvar j = 0; j < Y; j++) begin : g_top
        assign w_b[0][j]     = w_b_inj[j];
        assign w_unused_b[j] = ^w_b[X][j];
    end

    always_comb begin
        out_data = '0;
        if (r_state == S_DRAIN)
            for (int c = 0; c < c_CLEN; c++)
                if (r_ocnt == c_CW'(c)) out_data = w_acc[c];
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_matmul_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa_matmul_engine
//  Brief    : Randomized self-checking bench for sa_matmul_engine (3x3x3,
//             OUT_LEN=12) against a plain-arithmetic matrix model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sa_matmul_engine;

    localparam int c_OL   = 12;
    localparam int c_MAXV = (1 << (c_OL - 1)) - 1;
    localparam int c_MINV = -(1 << (c_OL - 1));
`ifdef SA_SAT_EN
    localparam int c_EXP127 = 2047;
`else
    localparam int c_EXP127 = -765;
`endif

    logic              clk = 1'b0;
    logic              sys_rst, SA_start, Xin_val, Yin_val, out_rdy;
    logic [1:0]        op_mode;
    logic [7:0]        Xin_data, Yin_data;
    logic              Xin_rdy, Yin_rdy, out_val, busy, done;
    logic [c_OL-1:0]   out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int model_c  [9];
    int cur_a    [9];
    int cur_b    [9];
    int last_out [9];

    sa_matmul_engine #(
        .X(3), .N(3), .Y(3), .IN_LEN(8), .OUT_LEN(c_OL)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .op_mode(op_mode), .SA_start(SA_start),
        .Xin_val(Xin_val), .Xin_rdy(Xin_rdy), .Xin_data(Xin_data),
        .Yin_val(Yin_val), .Yin_rdy(Yin_rdy), .Yin_data(Yin_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accumulator update with the configured overflow rule
    function automatic int step(input int acc, input int p, input bit sub);
        int s;
        s = sub ? acc - p : acc + p;
`ifdef SA_SAT_EN
        if (s > c_MAXV) s = c_MAXV;
        else if (s < c_MINV) s = c_MINV;
`else
        s = ((s % (1 << c_OL)) + (1 << c_OL)) % (1 << c_OL);
        if (s > c_MAXV) s -= (1 << c_OL);
`endif
        return s;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // a is row-major A[i][k]; b is row-major B[k][j] and is streamed column-major
    task automatic load(input int a[9], input int b[9], input bit probe);
        int xi = 0, yi = 0, cyc = 0, busy_seen = 0, extra_rdy = 0;
        bit probed = 1'b0;
        cur_a = a;
        cur_b = b;
        while ((xi < 9 || yi < 9) && cyc < 500) begin
            @(negedge clk);
            if (xi < 9) begin
                Xin_val  = ($urandom_range(0, 3) != 0);
                Xin_data = 8'(a[xi]);
            end else begin
                Xin_val  = probe;
                Xin_data = 8'h55;
            end
            if (yi < 9) begin
                Yin_val  = ($urandom_range(0, probe ? 3 : 1) == 0);
                Yin_data = 8'(b[(yi % 3) * 3 + (yi / 3)]);
            end else begin
                Yin_val = 1'b0;
            end
            SA_start = probe && (xi == 5) && !probed;
            if (SA_start) probed = 1'b1;
            #1;
            if (busy) busy_seen++;
            if (xi >= 9 && Xin_rdy) extra_rdy++;
            if (Xin_val && Xin_rdy) xi++;
            if (Yin_val && Yin_rdy) yi++;
            cyc++;
            @(posedge clk);
        end
        @(negedge clk);
        SA_start = 1'b0;
        Yin_val  = 1'b0;
        Xin_val  = probe;
        #1;
        if (probe && Xin_rdy) extra_rdy++;
        if (cyc >= 500) check("load_timeout", 0, 1);
        if (probe) begin
            check("start_in_load_busy", busy_seen, 0);
            check("x_rdy_past_full", extra_rdy, 0);
        end
        Xin_val = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 alternate 1-0-1, 2 random
    task automatic run(input logic [1:0] mode, input int rdy_mode, input bit chk_busy,
                       input string tag);
        int exp_c [9];
        int got [$];
        int busy_n = 0, done_n = 0, cyc = 0;
        bit fin = 1'b0, stalled = 1'b0;
        logic [c_OL-1:0] prev = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int acc;
                acc = (mode == 2'b01 || mode == 2'b10) ? model_c[i*3+j] : 0;
                for (int k = 0; k < 3; k++)
                    acc = step(acc, cur_a[i*3+k] * cur_b[k*3+j], mode == 2'b10);
                exp_c[i*3+j] = acc;
            end
        @(negedge clk);
        op_mode  = mode;
        SA_start = 1'b1;
        @(negedge clk);
        SA_start = 1'b0;
        op_mode  = 2'b00;
        while (!fin && cyc < 300) begin
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = (cyc % 2 == 0);
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (busy) busy_n++;
            if (done) done_n++;
            if (stalled) check($sformatf("%s_hold", tag), int'(out_data), int'(prev));
            if (out_val && out_rdy) got.push_back(int'($signed(out_data)));
            stalled = out_val && !out_rdy;
            prev    = out_data;
            if (done) fin = 1'b1;
            cyc++;
            @(negedge clk);
        end
        out_rdy = 1'b1;
        #1;
        if (!fin) check({tag, "_timeout"}, 0, 1);
        check({tag, "_xrdy_after_done"}, int'(Xin_rdy), 1);
        check({tag, "_yrdy_after_done"}, int'(Yin_rdy), 1);
        check({tag, "_busy_after_done"}, int'(busy), 0);
        if (chk_busy) check({tag, "_busy_cycles"}, busy_n, 16);
        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_words"}, got.size(), 9);
        for (int k = 0; k < 9; k++) begin
            last_out[k] = (k < got.size()) ? got[k] : -99999;
            check($sformatf("%s_c%0d", tag, k), last_out[k], exp_c[k]);
        end
        model_c = exp_c;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a [9];
        int b [9];
        int quiet;
        sys_rst = 1'b1; SA_start = 1'b0; op_mode = 2'b00;
        Xin_val = 1'b0; Yin_val = 1'b0; Xin_data = '0; Yin_data = '0; out_rdy = 1'b1;
        for (int k = 0; k < 9; k++) model_c[k] = 0;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        #1;
        check("rst_xrdy", int'(Xin_rdy), 1);
        check("rst_yrdy", int'(Yin_rdy), 1);
        check("rst_outval", int'(out_val), 0);
        check("rst_outdata", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // A = 1..9, B = identity through overwrite, accumulate, subtract
        for (int k = 0; k < 9; k++) begin
            a[k] = k + 1;
            b[k] = (k % 4 == 0) ? 1 : 0;
        end
        load(a, b, 1'b0);
        run(2'b00, 0, 1'b1, "ovw");
        check("ovw_lit_c8", last_out[8], 9);
        load(a, b, 1'b0);
        run(2'b01, 0, 1'b1, "acc");
        check("acc_lit_c8", last_out[8], 18);
        load(a, b, 1'b0);
        run(2'b10, 0, 1'b1, "sub");
        check("sub_lit_c0", last_out[0], 1);

        // Backpressure with alternating out_rdy
        for (int k = 0; k < 9; k++) begin a[k] = rnd8(); b[k] = rnd8(); end
        load(a, b, 1'b0);
        run(2'b00, 1, 1'b0, "stall");

        // Overflow: all operands 127 into a 12-bit accumulator
        for (int k = 0; k < 9; k++) begin a[k] = 127; b[k] = 127; end
        load(a, b, 1'b0);
        run(2'b00, 0, 1'b1, "ovf");
        check("ovf_lit_c4", last_out[4], c_EXP127);

        // SA_start during LOAD ignored, Xin_val held past a full buffer
        for (int k = 0; k < 9; k++) begin a[k] = rnd8(); b[k] = rnd8(); end
        load(a, b, 1'b1);
        run(2'b11, 2, 1'b0, "probe");

        // Reset in mid-COMPUTE
        for (int k = 0; k < 9; k++) begin a[k] = rnd8(); b[k] = rnd8(); end
        load(a, b, 1'b0);
        @(negedge clk);
        op_mode = 2'b01; SA_start = 1'b1;
        @(negedge clk);
        SA_start = 1'b0;
        repeat (2) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        check("mrst_xrdy", int'(Xin_rdy), 1);
        check("mrst_yrdy", int'(Yin_rdy), 1);
        check("mrst_outval", int'(out_val), 0);
        check("mrst_outdata", int'(out_data), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (out_val || busy) quiet++;
        end
        check("mrst_no_partial", quiet, 0);
        for (int k = 0; k < 9; k++) model_c[k] = 0;
        for (int k = 0; k < 9; k++) begin a[k] = rnd8(); b[k] = rnd8(); end
        load(a, b, 1'b0);
        run(2'b00, 0, 1'b1, "reload");

        // Random mode / backpressure mix
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 9; k++) begin a[k] = rnd8(); b[k] = rnd8(); end
            load(a, b, 1'b0);
            run(2'($urandom_range(0, 3)), 2, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
